// File: rtl/sd_dat_block_rx_if.sv
// Bus bundle for the SD 4-bit DAT block receiver: strobe/data/control
// towards the receiver, byte stream and status back out of it.
interface sd_dat_block_rx_if;
   logic       sd_sample;
   logic [3:0] dat_in;
   logic       start;
   logic       abort;
   logic       busy;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       done;
   logic       crc_err;
   logic       timeout;

   modport master (
      output sd_sample, dat_in, start, abort,
      input  busy, byte_data, byte_valid, done, crc_err, timeout
   );

   modport slave (
      input  sd_sample, dat_in, start, abort,
      output busy, byte_data, byte_valid, done, crc_err, timeout
   );
endinterface

// File: rtl/sd_dat_block_rx.sv
// SD 4-bit DAT read-direction block receiver: start-bit hunt with timeout,
// nibble-to-byte deserialisation, per-line CRC16 check and end-bit check.
// All protocol progress is gated by the sd_sample strobe; outputs registered.
module sd_dat_block_rx #(
   parameter int unsigned BLOCK_BYTES     = 512,
   parameter int unsigned TIMEOUT_STROBES = 65535
) (
   input logic              clk,
   input logic              reset,
   sd_dat_block_rx_if.slave bus
);
   localparam int unsigned NIBBLES  = 2 * BLOCK_BYTES;
   localparam int unsigned NW       = $clog2(NIBBLES) + 1;
   localparam logic [NW-1:0] LAST_NIB = NW'(NIBBLES - 1);
   localparam logic [19:0]   TO_LIM   = 20'(TIMEOUT_STROBES);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END} state_t;

   state_t           r_state, w_state_nxt;
   logic             r_busy, w_busy_nxt;
   logic [7:0]       r_byte_data, w_byte_data_nxt;
   logic             r_byte_valid, w_byte_valid_nxt;
   logic             r_done, w_done_nxt;
   logic             r_crc_err, w_crc_err_nxt;
   logic             r_timeout, w_timeout_nxt;
   logic [19:0]      r_tcnt, w_tcnt_nxt, w_tcnt_inc;
   logic [NW-1:0]    r_ncnt, w_ncnt_nxt;
   logic [3:0]       r_hi, w_hi_nxt;
   logic [3:0][15:0] r_crc, w_crc_nxt;
   logic [3:0]       r_ccnt, w_ccnt_nxt;

   // Serial CRC16-CCITT step (x^16+x^12+x^5+1), MSB first.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   assign w_tcnt_inc = r_tcnt + 20'd1;

   // Next-state and next-register computation; abort outranks everything.
   always_comb begin
      w_state_nxt      = r_state;
      w_busy_nxt       = r_busy;
      w_byte_data_nxt  = r_byte_data;
      w_byte_valid_nxt = 1'b0;
      w_done_nxt       = 1'b0;
      w_crc_err_nxt    = r_crc_err;
      w_timeout_nxt    = r_timeout;
      w_tcnt_nxt       = r_tcnt;
      w_ncnt_nxt       = r_ncnt;
      w_hi_nxt         = r_hi;
      w_crc_nxt        = r_crc;
      w_ccnt_nxt       = r_ccnt;
      if (r_state != S_IDLE && bus.abort) begin
         w_state_nxt = S_IDLE;
         w_busy_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  w_state_nxt   = S_WAIT_START;
                  w_busy_nxt    = 1'b1;
                  w_crc_err_nxt = 1'b0;
                  w_timeout_nxt = 1'b0;
                  w_tcnt_nxt    = '0;
               end
            end
            S_WAIT_START: begin
               if (bus.sd_sample) begin
                  if (bus.dat_in == 4'h0) begin
                     w_state_nxt = S_DATA;
                     w_crc_nxt   = '0;
                     w_ncnt_nxt  = '0;
                  end else begin
                     w_tcnt_nxt = w_tcnt_inc;
                     if (w_tcnt_inc == TO_LIM) begin
                        w_timeout_nxt = 1'b1;
                        w_busy_nxt    = 1'b0;
                        w_state_nxt   = S_IDLE;
                     end
                  end
               end
            end
            S_DATA: begin
               if (bus.sd_sample) begin
                  for (int unsigned i = 0; i < 4; i++)
                     w_crc_nxt[i[1:0]] = crc_step(r_crc[i[1:0]], bus.dat_in[i[1:0]]);
                  if (!r_ncnt[0]) begin
                     w_hi_nxt = bus.dat_in;
                  end else begin
                     w_byte_data_nxt  = {r_hi, bus.dat_in};
                     w_byte_valid_nxt = 1'b1;
                  end
                  if (r_ncnt == LAST_NIB) begin
                     w_state_nxt = S_CRC;
                     w_ccnt_nxt  = '0;
                  end else begin
                     w_ncnt_nxt = r_ncnt + 1'b1;
                  end
               end
            end
            S_CRC: begin
               // Each computed CRC is shifted out MSB-first alongside the
               // received bits, so only bit 15 is ever compared.
               if (bus.sd_sample) begin
                  for (int unsigned i = 0; i < 4; i++) begin
                     if (bus.dat_in[i[1:0]] != r_crc[i[1:0]][15])
                        w_crc_err_nxt = 1'b1;
                     w_crc_nxt[i[1:0]] = {r_crc[i[1:0]][14:0], 1'b0};
                  end
                  w_ccnt_nxt = r_ccnt + 4'd1;
                  if (r_ccnt == 4'd15)
                     w_state_nxt = S_END;
               end
            end
            S_END: begin
               if (bus.sd_sample) begin
                  if (bus.dat_in != 4'hF)
                     w_crc_err_nxt = 1'b1;
                  w_done_nxt  = 1'b1;
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_byte_data  <= '0;
         r_byte_valid <= 1'b0;
         r_done       <= 1'b0;
         r_crc_err    <= 1'b0;
         r_timeout    <= 1'b0;
         r_tcnt       <= '0;
         r_ncnt       <= '0;
         r_hi         <= '0;
         r_crc        <= '0;
         r_ccnt       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_busy       <= w_busy_nxt;
         r_byte_data  <= w_byte_data_nxt;
         r_byte_valid <= w_byte_valid_nxt;
         r_done       <= w_done_nxt;
         r_crc_err    <= w_crc_err_nxt;
         r_timeout    <= w_timeout_nxt;
         r_tcnt       <= w_tcnt_nxt;
         r_ncnt       <= w_ncnt_nxt;
         r_hi         <= w_hi_nxt;
         r_crc        <= w_crc_nxt;
         r_ccnt       <= w_ccnt_nxt;
      end
   end

   assign bus.busy       = r_busy;
   assign bus.byte_data  = r_byte_data;
   assign bus.byte_valid = r_byte_valid;
   assign bus.done       = r_done;
   assign bus.crc_err    = r_crc_err;
   assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_sd_dat_block_rx.sv
// Bench for sd_dat_block_rx with a 4-byte block and an 8-strobe timeout.
module tb_sd_dat_block_rx;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sd_dat_block_rx_if ifc();

   sd_dat_block_rx #(.BLOCK_BYTES(4), .TIMEOUT_STROBES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] got_q[$];
   int         done_cnt = 0;

   // Byte and done-pulse collector, sampled on the falling edge.
   always @(negedge clk) begin
      if (ifc.byte_valid) got_q.push_back(ifc.byte_data);
      if (ifc.done) done_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   // Reference CRC16 by polynomial long division of the line's bit stream
   // (8 nibbles of a 4-byte block) multiplied by x^16.
   function automatic logic [15:0] ref_crc(input logic [31:0] payload, input int line);
      logic [23:0] m;
      logic [3:0]  nib;
      m = '0;
      for (int n = 0; n < 8; n++) begin
         nib = payload[31-4*n -: 4];
         m[23-n] = nib[line];
      end
      for (int k = 23; k >= 16; k--)
         if (m[k]) m[k -: 17] = m[k -: 17] ^ 17'h11021;
      return m[15:0];
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic strobe(input logic [3:0] n, input int gap);
      ifc.dat_in    = n;
      ifc.sd_sample = 1'b1;
      @(posedge clk); #1;
      ifc.sd_sample = 1'b0;
      cyc(gap);
   endtask

   task automatic pulse_start();
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
   endtask

   task automatic pulse_abort();
      ifc.abort = 1'b1;
      @(posedge clk); #1;
      ifc.abort = 1'b0;
   endtask

   task automatic run_block(input string nm, input logic [31:0] payload, input int pre,
                            input logic [3:0] flip, input logic [3:0] end_nib,
                            input int start_at, input int gap_max, input logic exp_err);
      int          base_b, base_d;
      logic [15:0] crc [4];
      logic [3:0]  nib;
      base_b = got_q.size();
      base_d = done_cnt;
      pulse_start();
      check({nm, "/busy_after_start"}, ifc.busy, 1);
      check({nm, "/flags_cleared"}, {ifc.crc_err, ifc.timeout}, 0);
      for (int p = 0; p < pre; p++)
         strobe(4'($urandom_range(1, 15)), $urandom_range(0, gap_max));
      strobe(4'h0, $urandom_range(0, gap_max));
      for (int n = 0; n < 8; n++) begin
         if (n == start_at) pulse_start();
         strobe(payload[31-4*n -: 4], $urandom_range(0, gap_max));
      end
      for (int l = 0; l < 4; l++) crc[l] = ref_crc(payload, l);
      for (int k = 0; k < 16; k++) begin
         for (int l = 0; l < 4; l++) nib[l] = crc[l][15-k];
         if (k == 0) nib = nib ^ flip;
         strobe(nib, $urandom_range(0, gap_max));
      end
      check({nm, "/busy_before_end"}, ifc.busy, 1);
      strobe(end_nib, 0);
      cyc(2);
      check({nm, "/busy_after_end"}, ifc.busy, 0);
      check({nm, "/done_count"}, done_cnt - base_d, 1);
      check({nm, "/crc_err"}, ifc.crc_err, exp_err);
      check({nm, "/byte_count"}, got_q.size() - base_b, 4);
      if (got_q.size() >= base_b + 4)
         for (int b = 0; b < 4; b++)
            check({nm, "/byte"}, got_q[base_b+b], payload[31-8*b -: 8]);
   endtask

   typedef struct {
      string      name;
      logic [31:0] payload;
      int         pre;
      logic [3:0] flip;
      logic [3:0] end_nib;
      int         start_at;
      logic       exp_err;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int base_b, base_d;
      vecs[0] = '{"a5_block",   32'hA500_0000, 3, 4'h0, 4'hF, -1, 1'b0};
      vecs[1] = '{"zero_block", 32'h0000_0000, 0, 4'h0, 4'hF, -1, 1'b0};
      vecs[2] = '{"crc_flip",   32'h0000_0000, 0, 4'h4, 4'hF, -1, 1'b1};
      vecs[3] = '{"bad_end",    32'h3C5A_F00D, 1, 4'h0, 4'h7,  3, 1'b1};
      vecs[4] = '{"mixed",      32'hDEAD_BEEF, 5, 4'h0, 4'hF, -1, 1'b0};

      reset = 1'b1;
      ifc.sd_sample = 1'b0;
      ifc.dat_in    = 4'h0;
      ifc.start     = 1'b0;
      ifc.abort     = 1'b0;
      cyc(3);
      check("reset/outputs",
            {ifc.busy, ifc.byte_valid, ifc.done, ifc.crc_err, ifc.timeout, ifc.byte_data}, 0);
      reset = 1'b0;
      cyc(1);

      foreach (vecs[i])
         run_block(vecs[i].name, vecs[i].payload, vecs[i].pre, vecs[i].flip,
                   vecs[i].end_nib, vecs[i].start_at, 0, vecs[i].exp_err);

      // Timeout: partial-zero nibbles never count as a start bit.
      base_b = got_q.size();
      base_d = done_cnt;
      pulse_start();
      strobe(4'hF, 0); strobe(4'hE, 1); strobe(4'h1, 0); strobe(4'h7, 2);
      strobe(4'hF, 0); strobe(4'h8, 0); strobe(4'h3, 0);
      check("timeout/not_yet", {ifc.busy, ifc.timeout}, 2'b10);
      strobe(4'hB, 0);
      check("timeout/eighth_strobe", {ifc.busy, ifc.timeout}, 2'b01);
      strobe(4'h0, 2);
      check("timeout/no_done", done_cnt - base_d, 0);
      check("timeout/no_bytes", got_q.size() - base_b, 0);

      // Abort in IDLE and start+abort together leave the sticky flag alone.
      pulse_abort();
      check("idle_abort/timeout_kept", {ifc.busy, ifc.timeout}, 2'b01);
      ifc.start = 1'b1;
      ifc.abort = 1'b1;
      cyc(1);
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      cyc(1);
      check("start_abort/dropped", {ifc.busy, ifc.timeout}, 2'b01);

      // Abort mid-DATA after three nibbles.
      base_b = got_q.size();
      base_d = done_cnt;
      pulse_start();
      strobe(4'h0, 0);
      strobe(4'hA, 0); strobe(4'h5, 0); strobe(4'h3, 0);
      pulse_abort();
      check("abort/busy", ifc.busy, 0);
      strobe(4'h4, 0);
      cyc(3);
      check("abort/byte_count", got_q.size() - base_b, 1);
      if (got_q.size() > base_b) check("abort/byte", got_q[base_b], 8'hA5);
      check("abort/no_done", done_cnt - base_d, 0);
      run_block("after_abort", 32'h0123_4567, 2, 4'h0, 4'hF, -1, 1, 1'b0);

      // Asynchronous reset mid-block.
      base_b = got_q.size();
      base_d = done_cnt;
      pulse_start();
      strobe(4'h0, 0);
      strobe(4'h1, 0); strobe(4'h2, 0); strobe(4'h3, 0);
      reset = 1'b1;
      #2;
      check("reset_mid/outputs", {ifc.busy, ifc.byte_valid, ifc.done, ifc.crc_err}, 0);
      cyc(2);
      reset = 1'b0;
      strobe(4'h4, 0);
      cyc(2);
      check("reset_mid/bytes", got_q.size() - base_b, 1);
      check("reset_mid/no_done", done_cnt - base_d, 0);
      check("reset_mid/idle", ifc.busy, 0);

      // Randomized blocks with random gaps and corruptions.
      for (int r = 0; r < 10; r++) begin
         logic [31:0] pl;
         logic [3:0]  fl, en;
         int          sel;
         pl  = $urandom;
         sel = $urandom_range(0, 2);
         fl  = (sel == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
         en  = (sel == 2) ? 4'($urandom_range(0, 14)) : 4'hF;
         run_block("random", pl, $urandom_range(0, 6), fl, en, -1, 2,
                   (fl != 4'h0) || (en != 4'hF));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
